rvv_backend_decode_ctrl_pk: RTL and testbench

- Parametrised successor of the decode-to-uop-queue packer. Sits between the decode units and the Uop Queue.
- Compacts valid uops from NUM_INST in-order decoded instructions onto NUM_PUSH queue lanes.
- Pushes as many uops as the queue currently has room for; the old all-or-nothing "4 free slots" rule is removed.
- Tracks the resume uop index of a partially issued head instruction, pops finished instructions from the Command Queue, and supports flush and a stall counter.

---
 rtl/rvv_backend_decode_ctrl_pk_pkg.sv | 21 ++
 rtl/rvv_backend_uop_compact.sv | 99 +++++++++
 rtl/rvv_backend_decode_ctrl_pk.sv | 154 +++++++++++++++
 tb/tb_rvv_backend_decode_ctrl_pk.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_backend_decode_ctrl_pk_pkg.sv
// Shared types and defaults for the decode-to-uop-queue packer.
//   UOP_QUEUE_t     : one decoded uop as written into the Uop Queue
//   UOP_INDEX_WIDTH : width of a uop's index within its instruction
//   NUM_DE_INST     : decoded instructions presented per cycle (default)
//   NUM_DE_UOP      : uop slots per decoded instruction (default)
package rvv_backend_decode_ctrl_pk_pkg;

  localparam int NUM_DE_INST     = 2;
  localparam int NUM_DE_UOP      = 4;
  localparam int UOP_INDEX_WIDTH = 3;

  typedef struct packed {
    logic [7:0]                 inst_tag;
    logic [5:0]                 funct6;
    logic [4:0]                 vd_index;
    logic [UOP_INDEX_WIDTH-1:0] uop_index;
    logic                       first_uop_valid;
    logic                       last_uop_valid;
  } UOP_QUEUE_t;

endpackage

// File: rtl/rvv_backend_uop_compact.sv
// Combinational uop compactor.
// Maps NUM_INST x NUM_UOP thermometer-valid slots of the eligible
// instructions onto NUM_PUSH contiguous lanes, limited to 'limit' lanes.
//   inst_en     : instruction k is eligible (in-order prefix of valid insts)
//   uop_valid   : per-slot valid, thermometer from slot 0
//   uop         : decoded uops
//   limit       : lanes available this cycle, already capped at NUM_PUSH
//   push/dataout: compacted lane enables and data (unused lanes are 0)
//   cnt         : leading-ones count of each instruction's valid slots
//   pushed_cnt  : uops of each instruction that landed on a lane
//   all_pushed  : every counted uop of the instruction was pushed
//   last_pushed : a pushed uop of the instruction carries last_uop_valid
//   last_slot   : slot of the instruction's last pushed uop
//   total / n   : uops offered by eligible instructions / lanes used
module rvv_backend_uop_compact
  import rvv_backend_decode_ctrl_pk_pkg::*;
#(
  parameter  int NUM_INST = NUM_DE_INST,
  parameter  int NUM_UOP  = NUM_DE_UOP,
  parameter  int NUM_PUSH = 4,
  localparam int UW = $clog2(NUM_UOP + 1),
  localparam int LW = $clog2(NUM_INST * NUM_UOP + 1),
  localparam int SW = (NUM_UOP > 1) ? $clog2(NUM_UOP) : 1
)(
  input  logic [NUM_INST-1:0] inst_en,
  input  logic [NUM_UOP-1:0]  uop_valid  [NUM_INST],
  input  UOP_QUEUE_t          uop        [NUM_INST][NUM_UOP],
  input  logic [LW-1:0]       limit,
  output logic [NUM_PUSH-1:0] push,
  output UOP_QUEUE_t          dataout    [NUM_PUSH],
  output logic [UW-1:0]       cnt        [NUM_INST],
  output logic [UW-1:0]       pushed_cnt [NUM_INST],
  output logic [NUM_INST-1:0] all_pushed,
  output logic [NUM_INST-1:0] last_pushed,
  output logic [SW-1:0]       last_slot  [NUM_INST],
  output logic [LW-1:0]       total,
  output logic [LW-1:0]       n
);

  logic [UW-1:0] eff_cnt [NUM_INST];
  logic [LW-1:0] offset  [NUM_INST];

  // Leading-ones count per instruction and exclusive prefix sum of the
  // eligible counts: offset[k] is the first lane instruction k would use.
  always_comb begin
    logic          run;
    logic [LW-1:0] acc;
    acc = '0;
    run = 1'b0;
    for (int unsigned k = 0; k < NUM_INST; k++) begin
      cnt[k] = '0;
      run    = 1'b1;
      for (int unsigned s = 0; s < NUM_UOP; s++) begin
        run = run & uop_valid[k][s];
        if (run) cnt[k] = cnt[k] + 1'b1;
      end
      eff_cnt[k] = inst_en[k] ? cnt[k] : '0;
      offset[k]  = acc;
      acc        = acc + LW'(eff_cnt[k]);
    end
    total = acc;
    n     = (total < limit) ? total : limit;
  end

  // Per-instruction share of the n pushed lanes.
  always_comb begin
    logic [LW-1:0] room;
    room        = '0;
    all_pushed  = '0;
    last_pushed = '0;
    for (int unsigned k = 0; k < NUM_INST; k++) begin
      room          = (n > offset[k]) ? (n - offset[k]) : '0;
      pushed_cnt[k] = (room >= LW'(eff_cnt[k])) ? eff_cnt[k] : UW'(room);
      all_pushed[k] = (pushed_cnt[k] == eff_cnt[k]);
      for (int unsigned s = 0; s < NUM_UOP; s++) begin
        if ((UW'(s) < pushed_cnt[k]) && uop[k][s].last_uop_valid)
          last_pushed[k] = 1'b1;
      end
      last_slot[k] = (pushed_cnt[k] != '0) ? SW'(pushed_cnt[k] - 1'b1) : '0;
    end
  end

  // Lane j takes the slot whose prefix position equals j.
  always_comb begin
    push = '0;
    for (int unsigned j = 0; j < NUM_PUSH; j++) begin
      dataout[j] = '0;
      push[j]    = (LW'(j) < n);
      for (int unsigned k = 0; k < NUM_INST; k++) begin
        for (int unsigned s = 0; s < NUM_UOP; s++) begin
          if (push[j] && inst_en[k] && (UW'(s) < cnt[k]) &&
              (offset[k] + LW'(s) == LW'(j)))
            dataout[j] = uop[k][s];
        end
      end
    end
  end

endmodule

// File: rtl/rvv_backend_decode_ctrl_pk.sv
// Decode-to-Uop-Queue packer.
// Compacts the uops of in-order decoded instructions onto the Uop Queue
// write lanes, pushing as many as the queue has room for, pops finished
// instructions from the Command Queue and tracks where a partially issued
// head instruction resumes.
//   clk, rst_n       : clock, synchronous active-low reset
//   pkg_valid        : instruction k present (program order)
//   uop_valid_de2uq  : per-slot uop valid, thermometer from slot 0
//   uop_de2uq        : decoded uops
//   uq_free_cnt      : free Uop Queue entries this cycle
//   flush            : pipeline flush / trap
//   uop_index_remain : resume uop index for the head instruction's decode
//   pop              : Command Queue pop per instruction
//   push / dataout   : Uop Queue write enables (contiguous from lane 0) / data
//   stall_cnt        : saturating count of stalled cycles
module rvv_backend_decode_ctrl_pk
  import rvv_backend_decode_ctrl_pk_pkg::*;
#(
  parameter  int NUM_INST = NUM_DE_INST,
  parameter  int NUM_UOP  = NUM_DE_UOP,
  parameter  int NUM_PUSH = 4,
  parameter  int UQ_DEPTH = 16,
  parameter  int STALL_W  = 16,
  localparam int FW = $clog2(UQ_DEPTH + 1)
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_INST-1:0]        pkg_valid,
  input  logic [NUM_UOP-1:0]         uop_valid_de2uq [NUM_INST],
  input  UOP_QUEUE_t                 uop_de2uq       [NUM_INST][NUM_UOP],
  input  logic [FW-1:0]              uq_free_cnt,
  input  logic                       flush,
  output logic [UOP_INDEX_WIDTH-1:0] uop_index_remain,
  output logic [NUM_INST-1:0]        pop,
  output logic [NUM_PUSH-1:0]        push,
  output UOP_QUEUE_t                 dataout         [NUM_PUSH],
  output logic [STALL_W-1:0]         stall_cnt
);

  localparam int UW = $clog2(NUM_UOP + 1);
  localparam int LW = $clog2(NUM_INST * NUM_UOP + 1);
  localparam int SW = (NUM_UOP > 1) ? $clog2(NUM_UOP) : 1;

  logic [NUM_INST-1:0]        inst_en;
  logic [LW-1:0]              limit;
  logic [NUM_PUSH-1:0]        lane_push;
  logic [UW-1:0]              cnt        [NUM_INST];
  logic [UW-1:0]              pushed_cnt [NUM_INST];
  logic [NUM_INST-1:0]        all_pushed;
  logic [NUM_INST-1:0]        last_pushed;
  logic [SW-1:0]              last_slot  [NUM_INST];
  logic [LW-1:0]              total;
  logic [LW-1:0]              n;
  logic [NUM_INST-1:0]        pop_raw;
  logic [UOP_INDEX_WIDTH-1:0] remain_nxt;
  logic                       stall_inc;

  // The first absent instruction blocks everything behind it.
  always_comb begin
    logic run;
    run     = 1'b1;
    inst_en = '0;
    for (int unsigned k = 0; k < NUM_INST; k++) begin
      run        = run & pkg_valid[k];
      inst_en[k] = run;
    end
  end

  assign limit = (int'(uq_free_cnt) > NUM_PUSH) ? LW'(NUM_PUSH) : LW'(uq_free_cnt);

  rvv_backend_uop_compact #(
    .NUM_INST (NUM_INST),
    .NUM_UOP  (NUM_UOP),
    .NUM_PUSH (NUM_PUSH)
  ) u_compact (
    .inst_en     (inst_en),
    .uop_valid   (uop_valid_de2uq),
    .uop         (uop_de2uq),
    .limit       (limit),
    .push        (lane_push),
    .dataout     (dataout),
    .cnt         (cnt),
    .pushed_cnt  (pushed_cnt),
    .all_pushed  (all_pushed),
    .last_pushed (last_pushed),
    .last_slot   (last_slot),
    .total       (total),
    .n           (n)
  );

  // An instruction retires when it has no uops, or when all its uops went
  // out and one of them closes the instruction; pops stay in order.
  always_comb begin
    logic run;
    run     = 1'b1;
    pop_raw = '0;
    for (int unsigned k = 0; k < NUM_INST; k++) begin
      run        = run & pkg_valid[k] &
                   ((cnt[k] == '0) | (all_pushed[k] & last_pushed[k]));
      pop_raw[k] = run;
    end
  end

  assign push = (rst_n && !flush) ? lane_push : '0;
  assign pop  = (rst_n && !flush) ? pop_raw   : '0;

  // Resume index follows the first eligible instruction that is not popped,
  // if any of its uops went out this cycle.
  always_comb begin
    logic                       found;
    logic                       hit;
    logic [UOP_INDEX_WIDTH-1:0] hit_idx;
    found   = 1'b0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < NUM_INST; k++) begin
      if (!found && inst_en[k] && !pop_raw[k]) begin
        found = 1'b1;
        if (pushed_cnt[k] != '0) begin
          hit     = 1'b1;
          hit_idx = uop_de2uq[k][last_slot[k]].uop_index + 1'b1;
        end
      end
    end
    if (flush)         remain_nxt = '0;
    else if (hit)      remain_nxt = hit_idx;
    else if (|pop_raw) remain_nxt = '0;
    else               remain_nxt = uop_index_remain;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) uop_index_remain <= '0;
    else        uop_index_remain <= remain_nxt;
  end

  assign stall_inc = pkg_valid[0] & ~flush & (n == '0) & (total != '0);

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_inc && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  // Valid slots must be a run of ones starting at slot 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned k = 0; k < NUM_INST; k++) begin
        assert ((uop_valid_de2uq[k] & (uop_valid_de2uq[k] + 1'b1)) == '0);
      end
    end
  end

endmodule

// File: tb/tb_rvv_backend_decode_ctrl_pk.sv
module tb_rvv_backend_decode_ctrl_pk;
  import rvv_backend_decode_ctrl_pk_pkg::*;

  localparam int NI = 2;
  localparam int NU = 4;
  localparam int NP = 4;
  localparam int FW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst_n;
  logic [NI-1:0]              pkg_valid;
  logic [NU-1:0]              uop_valid [NI];
  UOP_QUEUE_t                 uop       [NI][NU];
  logic [FW-1:0]              free;
  logic                       flush;
  logic [UOP_INDEX_WIDTH-1:0] remain, remain_s;
  logic [NI-1:0]              pop, pop_s;
  logic [NP-1:0]              push, push_s;
  UOP_QUEUE_t                 dataout   [NP];
  UOP_QUEUE_t                 dataout_s [NP];
  logic [15:0]                stall_cnt;
  logic [3:0]                 stall_s;

  rvv_backend_decode_ctrl_pk #(
    .NUM_INST(NI), .NUM_UOP(NU), .NUM_PUSH(NP), .UQ_DEPTH(16), .STALL_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pkg_valid(pkg_valid), .uop_valid_de2uq(uop_valid),
    .uop_de2uq(uop), .uq_free_cnt(free), .flush(flush), .uop_index_remain(remain),
    .pop(pop), .push(push), .dataout(dataout), .stall_cnt(stall_cnt)
  );

  // Narrow stall counter instance so saturation is reachable quickly.
  rvv_backend_decode_ctrl_pk #(
    .NUM_INST(NI), .NUM_UOP(NU), .NUM_PUSH(NP), .UQ_DEPTH(16), .STALL_W(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pkg_valid(pkg_valid), .uop_valid_de2uq(uop_valid),
    .uop_de2uq(uop), .uq_free_cnt(free), .flush(flush), .uop_index_remain(remain_s),
    .pop(pop_s), .push(push_s), .dataout(dataout_s), .stall_cnt(stall_s)
  );

  int tests = 0;
  int fails = 0;

  // reference model state and per-cycle expectations
  int            m_remain, m_stall, m_stall4;
  logic [NP-1:0] e_push;
  logic [NI-1:0] e_pop;
  UOP_QUEUE_t    e_data [NP];
  int            e_remain_nxt;
  bit            e_stall_inc;

  task automatic set_inst(input int k, input int c, input int base, input int last_at);
    logic [31:0] r;
    for (int s = 0; s < NU; s++) begin
      r = $urandom;
      uop[k][s] = r[$bits(UOP_QUEUE_t)-1:0];
      uop[k][s].uop_index = UOP_INDEX_WIDTH'(base + s);
      uop[k][s].last_uop_valid = (s == last_at);
      uop_valid[k][s] = (s < c);
    end
  endtask

  task automatic clear_inputs();
    pkg_valid = '0; free = '0; flush = 1'b0;
    for (int k = 0; k < NI; k++) set_inst(k, 0, 0, -1);
  endtask

  // Builds the ordered uop list and derives everything from it.
  task automatic model_eval();
    UOP_QUEUE_t L[$];
    int own[$];
    int n, c, pushed, lastidx, hidx;
    bit p, elig, lastseen, found, hit;
    for (int k = 0; k < NI; k++) begin
      if (!pkg_valid[k]) break;
      c = 0;
      while (c < NU && uop_valid[k][c]) c++;
      for (int s = 0; s < c; s++) begin L.push_back(uop[k][s]); own.push_back(k); end
    end
    n = L.size();
    if (int'(free) < n) n = int'(free);
    if (NP < n) n = NP;
    e_push = '0;
    for (int j = 0; j < NP; j++) begin
      e_data[j] = '0;
      if (j < n) begin e_push[j] = 1'b1; e_data[j] = L[j]; end
    end
    e_pop = '0; p = 1; elig = 1; found = 0; hit = 0; hidx = 0;
    for (int k = 0; k < NI; k++) begin
      c = 0;
      while (c < NU && uop_valid[k][c]) c++;
      pushed = 0; lastseen = 0; lastidx = 0;
      for (int j = 0; j < n; j++)
        if (own[j] == k) begin
          pushed++; lastseen |= L[j].last_uop_valid; lastidx = int'(L[j].uop_index);
        end
      elig = elig && pkg_valid[k];
      p = p && pkg_valid[k] && (c == 0 || (pushed == c && lastseen));
      e_pop[k] = p;
      if (elig && !p && !found) begin
        found = 1;
        if (pushed > 0) begin hit = 1; hidx = (lastidx + 1) % (1 << UOP_INDEX_WIDTH); end
      end
    end
    if (flush)      e_remain_nxt = 0;
    else if (hit)   e_remain_nxt = hidx;
    else if (|e_pop) e_remain_nxt = 0;
    else            e_remain_nxt = m_remain;
    e_stall_inc = pkg_valid[0] && !flush && n == 0 && L.size() > 0;
    if (flush || !rst_n) begin e_push = '0; e_pop = '0; end
    if (!rst_n) e_remain_nxt = 0;
  endtask

  task automatic test_reset();
    tests++; if (remain !== 3'd0) begin fails++; $display("FAIL reset_init_remain got=%0d exp=0", remain); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_init_stall got=%0d exp=0", stall_cnt); end
    // leave a partial head (remain=3), then reset over it
    pkg_valid = 2'b01; set_inst(0, 4, 0, 3); free = 5'd3;
    @(posedge clk); #1;
    tests++; if (remain !== 3'd3) begin fails++; $display("FAIL reset_pre_remain got=%0d exp=3", remain); end
    rst_n = 1'b0; #1;
    tests++; if (push !== 4'b0000) begin fails++; $display("FAIL reset_push got=%b exp=0000", push); end
    tests++; if (pop !== 2'b00) begin fails++; $display("FAIL reset_pop got=%b exp=00", pop); end
    @(posedge clk); #1;
    tests++; if (remain !== 3'd0) begin fails++; $display("FAIL reset_remain got=%0d exp=0", remain); end
    tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    rst_n = 1'b1; clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_pack();
    pkg_valid = 2'b11; set_inst(0, 2, 0, 1); set_inst(1, 2, 0, 1); free = 5'd8; #1;
    tests++; if (push !== 4'b1111) begin fails++; $display("FAIL pack_push got=%b exp=1111", push); end
    tests++; if (pop !== 2'b11) begin fails++; $display("FAIL pack_pop got=%b exp=11", pop); end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (dataout[j] !== uop[j/2][j%2]) begin
        fails++; $display("FAIL pack_data%0d got=%h exp=%h", j, dataout[j], uop[j/2][j%2]);
      end
    end
    @(posedge clk); #1;
    tests++; if (remain !== 3'd0) begin fails++; $display("FAIL pack_remain got=%0d exp=0", remain); end
  endtask

  task automatic test_partial();
    pkg_valid = 2'b01; set_inst(0, 4, 0, 3); set_inst(1, 0, 0, -1); free = 5'd3; #1;
    tests++; if (push !== 4'b0111) begin fails++; $display("FAIL partial_push got=%b exp=0111", push); end
    tests++; if (pop !== 2'b00) begin fails++; $display("FAIL partial_pop got=%b exp=00", pop); end
    for (int j = 0; j < 3; j++) begin
      tests++;
      if (dataout[j] !== uop[0][j]) begin
        fails++; $display("FAIL partial_data%0d got=%h exp=%h", j, dataout[j], uop[0][j]);
      end
    end
    @(posedge clk); #1;
    tests++; if (remain !== 3'd3) begin fails++; $display("FAIL partial_remain got=%0d exp=3", remain); end
    // decoder supplies the remaining uop
    set_inst(0, 1, 3, 0); #1;
    tests++; if (push !== 4'b0001) begin fails++; $display("FAIL resume_push got=%b exp=0001", push); end
    tests++; if (pop !== 2'b01) begin fails++; $display("FAIL resume_pop got=%b exp=01", pop); end
    @(posedge clk); #1;
    tests++; if (remain !== 3'd0) begin fails++; $display("FAIL resume_remain got=%0d exp=0", remain); end
  endtask

  task automatic test_split();
    pkg_valid = 2'b11; set_inst(0, 1, 0, 0); set_inst(1, 4, 0, -1); free = 5'd16; #1;
    tests++; if (push !== 4'b1111) begin fails++; $display("FAIL split_push got=%b exp=1111", push); end
    tests++; if (pop !== 2'b01) begin fails++; $display("FAIL split_pop got=%b exp=01", pop); end
    tests++; if (dataout[0] !== uop[0][0]) begin fails++; $display("FAIL split_data0 got=%h exp=%h", dataout[0], uop[0][0]); end
    for (int j = 1; j < 4; j++) begin
      tests++;
      if (dataout[j] !== uop[1][j-1]) begin
        fails++; $display("FAIL split_data%0d got=%h exp=%h", j, dataout[j], uop[1][j-1]);
      end
    end
    @(posedge clk); #1;
    tests++; if (remain !== 3'd3) begin fails++; $display("FAIL split_remain got=%0d exp=3", remain); end
  endtask

  task automatic test_no_space();
    rst_n = 1'b0; clear_inputs(); @(posedge clk); #1; rst_n = 1'b1;
    pkg_valid = 2'b01; set_inst(0, 2, 0, 1); free = 5'd0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      tests++; if (push !== 4'b0000 || pop !== 2'b00) begin
        fails++; $display("FAIL nospace_io push=%b pop=%b exp=0000/00", push, pop);
      end
      @(posedge clk); #1;
      tests++; if (stall_cnt !== 16'(i)) begin fails++; $display("FAIL nospace_stall got=%0d exp=%0d", stall_cnt, i); end
    end
    // zero-uop head pops without space; the stalled follower still counts
    pkg_valid = 2'b11; set_inst(0, 0, 0, -1); set_inst(1, 2, 0, 1); #1;
    tests++; if (pop !== 2'b01) begin fails++; $display("FAIL zero_uop_pop got=%b exp=01", pop); end
    tests++; if (push !== 4'b0000) begin fails++; $display("FAIL zero_uop_push got=%b exp=0000", push); end
    @(posedge clk); #1;
    tests++; if (stall_cnt !== 16'd4) begin fails++; $display("FAIL zero_uop_stall got=%0d exp=4", stall_cnt); end
    // absent head blocks the rest
    pkg_valid = 2'b10; free = 5'd16; #1;
    tests++; if (push !== 4'b0000 || pop !== 2'b00) begin
      fails++; $display("FAIL blocked_io push=%b pop=%b exp=0000/00", push, pop);
    end
    @(posedge clk); #1;
    tests++; if (stall_cnt !== 16'd4) begin fails++; $display("FAIL blocked_stall got=%0d exp=4", stall_cnt); end
    pkg_valid = 2'b01; set_inst(0, 2, 0, 1); free = 5'd0;
    repeat (12) @(posedge clk);
    #1;
    tests++; if (stall_s !== 4'hF) begin fails++; $display("FAIL stall_saturate got=%0d exp=15", stall_s); end
    tests++; if (stall_cnt !== 16'd16) begin fails++; $display("FAIL stall_count got=%0d exp=16", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_flush();
    pkg_valid = 2'b01; set_inst(0, 4, 1, -1); free = 5'd4;
    @(posedge clk); #1;
    tests++; if (remain !== 3'd5) begin fails++; $display("FAIL flush_pre_remain got=%0d exp=5", remain); end
    set_inst(0, 4, 5, 3); free = 5'd16; flush = 1'b1; #1;
    tests++; if (push !== 4'b0000) begin fails++; $display("FAIL flush_push got=%b exp=0000", push); end
    tests++; if (pop !== 2'b00) begin fails++; $display("FAIL flush_pop got=%b exp=00", pop); end
    @(posedge clk); #1;
    tests++; if (remain !== 3'd0) begin fails++; $display("FAIL flush_remain got=%0d exp=0", remain); end
    clear_inputs();
  endtask

  task automatic test_random();
    int c;
    rst_n = 1'b0; clear_inputs(); @(posedge clk); #1; rst_n = 1'b1;
    m_remain = 0; m_stall = 0; m_stall4 = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NI; k++) begin
        pkg_valid[k] = ($urandom_range(0, 3) != 0);
        c = $urandom_range(0, NU);
        set_inst(k, c, $urandom_range(0, 7),
                 (c == 0 || $urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, c - 1));
      end
      free  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 16));
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 39) != 0);
      #1;
      model_eval();
      tests++; if (push !== e_push) begin fails++; $display("FAIL rnd_push cyc=%0d got=%b exp=%b", cyc, push, e_push); end
      tests++; if (pop !== e_pop) begin fails++; $display("FAIL rnd_pop cyc=%0d got=%b exp=%b", cyc, pop, e_pop); end
      if (rst_n && !flush) begin
        for (int j = 0; j < NP; j++) begin
          tests++;
          if (dataout[j] !== e_data[j]) begin
            fails++; $display("FAIL rnd_data%0d cyc=%0d got=%h exp=%h", j, cyc, dataout[j], e_data[j]);
          end
        end
      end
      tests++; if (remain !== UOP_INDEX_WIDTH'(m_remain)) begin
        fails++; $display("FAIL rnd_remain cyc=%0d got=%0d exp=%0d", cyc, remain, m_remain);
      end
      tests++; if (stall_cnt !== 16'(m_stall) || stall_s !== 4'(m_stall4)) begin
        fails++; $display("FAIL rnd_stall cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stall_cnt, stall_s, m_stall, m_stall4);
      end
      @(posedge clk); #1;
      m_remain = e_remain_nxt;
      if (!rst_n) begin m_stall = 0; m_stall4 = 0; end
      else if (e_stall_inc) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
    end
    rst_n = 1'b1; clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0; clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    test_reset();
    test_pack();
    test_partial();
    test_split();
    test_no_space();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
